// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arbiter
//  Description : Shares the single register-file write port between the
//                retiring pipeline instruction and a one-entry buffer that
//                holds a long-latency (mul/div) result. The buffer yields to
//                pipeline writes until a starvation limit forces it through,
//                but always goes first when both target the same register.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    output logic        wb_ready,
    input  logic        llu_valid,
    input  logic [4:0]  llu_addr,
    input  logic [31:0] llu_data,
    input  logic [31:0] llu_pc,
    output logic        llu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int c_CNT_W = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PEND  = 2'd1;
    localparam logic [1:0] c_FORCE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_buf_full;
    logic [4:0]         r_buf_addr;
    logic [31:0]        r_buf_data;
    logic [31:0]        r_buf_pc;
    logic               r_llu_ready;

    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [31:0]        r_rf_wdata;
    logic [31:0]        r_dbg_pc;
    logic [3:0]         r_dbg_wen;
    logic [4:0]         r_dbg_wnum;
    logic [31:0]        r_dbg_wdata;

    logic               w_waw;
    logic               w_wb_ready;
    logic               w_retire;
    logic               w_pipe_write;
    logic               w_buf_grant;
    logic               w_buf_lose;
    logic               w_accept;
    logic               w_full_next;
    logic [c_CNT_W-1:0] w_cnt_inc;

    // Grant decision: who owns the write port this cycle
    always_comb begin
        w_waw        = wb_valid & wb_we & (wb_addr == r_buf_addr);
        w_wb_ready   = 1'b0;
        if (!reset) begin
            case (r_state)
                c_IDLE:  w_wb_ready = 1'b1;
                c_PEND:  w_wb_ready = ~w_waw;
                default: w_wb_ready = 1'b0;
            endcase
        end
        w_retire     = wb_valid & w_wb_ready;
        w_pipe_write = w_retire & wb_we;
        // A retiring store leaves the port free, so the buffer drains alongside it
        w_buf_grant  = (r_state == c_FORCE) | ((r_state == c_PEND) & ~w_pipe_write);
        w_buf_lose   = (r_state == c_PEND) & w_pipe_write;
        w_accept     = ~r_buf_full & llu_valid & r_llu_ready;
        w_cnt_inc    = r_cnt + 1'b1;
        w_full_next  = w_buf_grant ? 1'b0 : (r_buf_full | w_accept);
    end

    assign wb_ready = w_wb_ready;

    // Buffer FSM: capture, count lost arbitrations, force after the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_buf_full  <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_buf_pc    <= '0;
            r_llu_ready <= 1'b0;
        end else begin
            r_buf_full  <= w_full_next;
            r_llu_ready <= ~w_full_next;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_buf_addr <= llu_addr;
                        r_buf_data <= llu_data;
                        r_buf_pc   <= llu_pc;
                        r_cnt      <= '0;
                        r_state    <= c_PEND;
                    end
                end
                c_PEND: begin
                    if (w_buf_grant) begin
                        r_state <= c_IDLE;
                    end else if (w_buf_lose) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= c_LIMIT) begin
                            r_state <= c_FORCE;
                        end
                    end
                end
                c_FORCE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Registered write port and trace; r0 writes are granted but not issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_dbg_pc    <= '0;
            r_dbg_wen   <= '0;
            r_dbg_wnum  <= '0;
            r_dbg_wdata <= '0;
        end else if (w_buf_grant) begin
            r_rf_we     <= (r_buf_addr != 5'd0);
            r_rf_waddr  <= r_buf_addr;
            r_rf_wdata  <= r_buf_data;
            r_dbg_pc    <= r_buf_pc;
            r_dbg_wen   <= (r_buf_addr != 5'd0) ? 4'b1111 : 4'b0000;
            r_dbg_wnum  <= r_buf_addr;
            r_dbg_wdata <= r_buf_data;
        end else if (w_pipe_write) begin
            r_rf_we     <= (wb_addr != 5'd0);
            r_rf_waddr  <= wb_addr;
            r_rf_wdata  <= wb_data;
            r_dbg_pc    <= wb_pc;
            r_dbg_wen   <= (wb_addr != 5'd0) ? 4'b1111 : 4'b0000;
            r_dbg_wnum  <= wb_addr;
            r_dbg_wdata <= wb_data;
        end else if (w_retire) begin
            r_rf_we     <= 1'b0;
            r_dbg_pc    <= wb_pc;
            r_dbg_wen   <= 4'b0000;
        end else begin
            r_rf_we     <= 1'b0;
            r_dbg_wen   <= 4'b0000;
        end
    end

    assign llu_ready         = r_llu_ready;
    assign rf_we             = r_rf_we;
    assign rf_waddr          = r_rf_waddr;
    assign rf_wdata          = r_rf_wdata;
    assign debug_wb_pc       = r_dbg_pc;
    assign debug_wb_rf_wen   = r_dbg_wen;
    assign debug_wb_rf_wnum  = r_dbg_wnum;
    assign debug_wb_rf_wdata = r_dbg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wport_arbiter
//  Description : Self-checking bench for rf_wport_arbiter: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;

    localparam int LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, wb_pc;
    logic        wb_ready;
    logic        llu_valid;
    logic [4:0]  llu_addr;
    logic [31:0] llu_data, llu_pc;
    logic        llu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    rf_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_ready(wb_ready),
        .llu_valid(llu_valid), .llu_addr(llu_addr), .llu_data(llu_data), .llu_pc(llu_pc),
        .llu_ready(llu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_wb(input logic v, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
        wb_valid = v; wb_we = we; wb_addr = a; wb_data = d; wb_pc = pc;
    endtask

    task automatic set_llu(input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] pc);
        llu_valid = v; llu_addr = a; llu_data = d; llu_pc = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_wb(1'b1, 1'b1, 5'd5, 32'h1234, 32'h40);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL rst_wb_ready got %b want 0", wb_ready); end
        checks++; if (llu_ready !== 1'b0) begin errors++; $display("FAIL rst_llu_ready got %b want 0", llu_ready); end
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++;
            $display("FAIL rst_rf got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0 || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin errors++;
            $display("FAIL rst_debug got pc=%h wen=%b n=%0d d=%h want all 0", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata); end
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_llu_ready got %b want 1", llu_ready); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wb_ready got %b want 1", wb_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_rf_we got %b want 0", rf_we); end
    endtask

    task automatic test_idle_write();
        set_wb(1'b1, 1'b1, 5'd5, 32'h11, 32'h100);
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL idle_wb_ready got %b want 1", wb_ready); end
        @(negedge clk);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin errors++;
            $display("FAIL idle_write got we=%b a=%0d d=%h want 1/5/11", rf_we, rf_waddr, rf_wdata); end
        checks++; if (debug_wb_rf_wen !== 4'b1111 || debug_wb_pc !== 32'h100 || debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h11) begin errors++;
            $display("FAIL idle_debug got wen=%b pc=%h n=%0d d=%h want 1111/100/5/11", debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11 || debug_wb_rf_wen !== 4'd0) begin errors++;
            $display("FAIL idle_hold got we=%b a=%0d d=%h wen=%b want 0/5/11/0000", rf_we, rf_waddr, rf_wdata, debug_wb_rf_wen); end
    endtask

    task automatic test_llu_drain();
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL llu_pre_ready got %b want 1", llu_ready); end
        set_llu(1'b1, 5'd7, 32'hAB, 32'h200);
        @(negedge clk);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (llu_ready !== 1'b0) begin errors++; $display("FAIL llu_busy got %b want 0", llu_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL llu_no_bypass got rf_we=%b want 0", rf_we); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAB || debug_wb_pc !== 32'h200) begin errors++;
            $display("FAIL llu_write got we=%b a=%0d d=%h pc=%h want 1/7/ab/200", rf_we, rf_waddr, rf_wdata, debug_wb_pc); end
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL llu_ready_back got %b want 1", llu_ready); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL llu_single_write got rf_we=%b want 0", rf_we); end
    endtask

    task automatic test_starvation();
        set_llu(1'b1, 5'd12, 32'hC0DE, 32'h300);
        @(negedge clk);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i <= LIMIT; i++) begin
            set_wb(1'b1, 1'b1, 5'd3, 32'h30 + i, 32'h310 + 4 * i);
            #1;
            checks++; if (wb_ready !== (i < LIMIT)) begin errors++; $display("FAIL starve_ready[%0d] got %b want %b", i, wb_ready, (i < LIMIT)); end
            @(negedge clk);
            if (i < LIMIT) begin
                checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h30 + i) begin errors++;
                    $display("FAIL starve_pipe[%0d] got we=%b a=%0d d=%h want 1/3/%h", i, rf_we, rf_waddr, rf_wdata, 32'h30 + i); end
            end else begin
                checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0DE || debug_wb_pc !== 32'h300) begin errors++;
                    $display("FAIL starve_force got we=%b a=%0d d=%h pc=%h want 1/12/c0de/300", rf_we, rf_waddr, rf_wdata, debug_wb_pc); end
                checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL starve_llu_ready got %b want 1", llu_ready); end
            end
        end
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_waw();
        set_llu(1'b1, 5'd9, 32'h99, 32'h400);
        @(negedge clk);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        set_wb(1'b1, 1'b1, 5'd9, 32'h55, 32'h404);
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b want 0", wb_ready); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || debug_wb_pc !== 32'h400) begin errors++;
            $display("FAIL waw_first got we=%b a=%0d d=%h pc=%h want 1/9/99/400", rf_we, rf_waddr, rf_wdata, debug_wb_pc); end
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL waw_release got %b want 1", wb_ready); end
        @(negedge clk);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h55 || debug_wb_pc !== 32'h404) begin errors++;
            $display("FAIL waw_second got we=%b a=%0d d=%h pc=%h want 1/9/55/404", rf_we, rf_waddr, rf_wdata, debug_wb_pc); end
        @(negedge clk);
    endtask

    task automatic test_store_drain();
        set_llu(1'b1, 5'd10, 32'hAA, 32'h500);
        @(negedge clk);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        set_wb(1'b1, 1'b0, 5'd4, 32'hDEAD, 32'h504);
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b want 1", wb_ready); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hAA || debug_wb_pc !== 32'h500 || debug_wb_rf_wen !== 4'b1111) begin errors++;
            $display("FAIL store_drain got we=%b a=%0d d=%h pc=%h wen=%b want 1/10/aa/500/1111", rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_wen); end
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL store_llu_ready got %b want 1", llu_ready); end
        set_wb(1'b1, 1'b0, 5'd4, 32'hBEEF, 32'h508);
        @(negedge clk);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'd0 || debug_wb_pc !== 32'h508) begin errors++;
            $display("FAIL store_plain got we=%b wen=%b pc=%h want 0/0000/508", rf_we, debug_wb_rf_wen, debug_wb_pc); end
        @(negedge clk);
    endtask

    task automatic test_r0_and_reset();
        set_wb(1'b1, 1'b1, 5'd0, 32'hFF, 32'h600);
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", wb_ready); end
        @(negedge clk);
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'd0) begin errors++;
            $display("FAIL r0_write got we=%b wen=%b want 0/0000", rf_we, debug_wb_rf_wen); end
        set_llu(1'b1, 5'd11, 32'hBB, 32'h700);
        @(negedge clk);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (llu_ready !== 1'b0) begin errors++; $display("FAIL midrst_full got llu_ready=%b want 0", llu_ready); end
        reset = 1'b1;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL midrst_wb_ready got %b want 0", wb_ready); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || llu_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_outputs got we=%b a=%0d llu_ready=%b want 0/0/0", rf_we, rf_waddr, llu_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || llu_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_after got we=%b llu_ready=%b want 0/1", rf_we, llu_ready); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_no_write got we=%b want 0", rf_we); end
    endtask

    // Reference model: buffer contents plus a count of lost arbitrations
    logic        m_full, m_force, m_llu_ready;
    int          m_losses;
    logic [4:0]  m_baddr;
    logic [31:0] m_bdata, m_bpc;
    logic        e_rf_we;
    logic [4:0]  e_waddr, e_wnum;
    logic [31:0] e_wdata, e_dpc, e_dwdata;
    logic [3:0]  e_wen;

    task automatic test_random();
        logic e_ready, retire, buf_go;
        for (int n = 0; n < 800; n++) begin
            if (n > 0) begin
                checks++; if (rf_we !== e_rf_we || rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin errors++;
                    $display("FAIL rand_rf[%0d] got we=%b a=%0d d=%h want %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, e_rf_we, e_waddr, e_wdata); end
                checks++; if (debug_wb_pc !== e_dpc || debug_wb_rf_wen !== e_wen || debug_wb_rf_wnum !== e_wnum || debug_wb_rf_wdata !== e_dwdata) begin errors++;
                    $display("FAIL rand_debug[%0d] got pc=%h wen=%b n=%0d d=%h want %h/%b/%0d/%h", n, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, e_dpc, e_wen, e_wnum, e_dwdata); end
                checks++; if (llu_ready !== m_llu_ready) begin errors++; $display("FAIL rand_llu_ready[%0d] got %b want %b", n, llu_ready, m_llu_ready); end
            end
            reset = (n == 0) || ($urandom_range(0, 63) == 0);
            set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom, $urandom);
            set_llu($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom, $urandom);
            #1;
            if (reset) e_ready = 1'b0;
            else if (!m_full) e_ready = 1'b1;
            else if (m_force) e_ready = 1'b0;
            else e_ready = !(wb_valid && wb_we && wb_addr == m_baddr);
            checks++; if (wb_ready !== e_ready) begin errors++; $display("FAIL rand_wb_ready[%0d] got %b want %b", n, wb_ready, e_ready); end
            if (reset) begin
                m_full = 0; m_force = 0; m_losses = 0; m_llu_ready = 0;
                e_rf_we = 0; e_waddr = 0; e_wdata = 0; e_dpc = 0; e_wen = 0; e_wnum = 0; e_dwdata = 0;
            end else begin
                retire = wb_valid && e_ready;
                buf_go = m_full && (m_force || !(retire && wb_we));
                if (buf_go) begin
                    e_rf_we = (m_baddr != 0); e_waddr = m_baddr; e_wdata = m_bdata; e_dpc = m_bpc;
                    e_wen = e_rf_we ? 4'hF : 4'h0; e_wnum = m_baddr; e_dwdata = m_bdata;
                end else if (retire && wb_we) begin
                    e_rf_we = (wb_addr != 0); e_waddr = wb_addr; e_wdata = wb_data; e_dpc = wb_pc;
                    e_wen = e_rf_we ? 4'hF : 4'h0; e_wnum = wb_addr; e_dwdata = wb_data;
                end else if (retire) begin
                    e_rf_we = 0; e_wen = 0; e_dpc = wb_pc;
                end else begin
                    e_rf_we = 0; e_wen = 0;
                end
                if (buf_go) begin
                    m_full = 0;
                end else if (m_full) begin
                    m_losses++;
                    if (m_losses >= LIMIT) m_force = 1;
                end else if (llu_valid && m_llu_ready) begin
                    m_full = 1; m_force = 0; m_losses = 0;
                    m_baddr = llu_addr; m_bdata = llu_data; m_bpc = llu_pc;
                end
                m_llu_ready = !m_full;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        set_llu(1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        m_full = 0; m_force = 0; m_llu_ready = 0; m_losses = 0;
        m_baddr = 0; m_bdata = 0; m_bpc = 0;
        test_reset();
        test_idle_write();
        test_llu_drain();
        test_starvation();
        test_waw();
        test_store_drain();
        test_r0_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wport_arbiter.md
RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: the number of cycles a buffered long-latency result may lose arbitration before it is forced.
REQ-002 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high.
REQ-004 Ports wb_valid / wb_we / wb_addr / wb_data / wb_pc, input, 1/1/5/32/32: retiring pipeline instruction, its write enable, destination, write data and PC.
REQ-005 Port wb_ready, output, 1: combinational; the pipeline instruction retires this cycle when wb_valid & wb_ready.
REQ-006 Ports llu_valid / llu_addr / llu_data / llu_pc, input, 1/5/32/32: long-latency unit (mul/div) result.
REQ-007 Port llu_ready, output, 1: registered; equals ~buf_full.
REQ-008 Ports rf_we / rf_waddr / rf_wdata, output, 1/5/32: registered register-file write port.
REQ-009 Ports debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata, output, 32/4/5/32: registered trace of the write issued this cycle.

Function
REQ-010 One-entry buffer (addr, data, pc, full) SHALL capture the LLU result when llu_valid & llu_ready; there is no same-cycle bypass.
REQ-011 FSM states: IDLE (buffer empty), PEND (buffer full, counting), FORCE (buffer full, starvation limit reached).
REQ-012 Grant rule, evaluated each cycle:
  - FORCE: grant the buffer; wb_ready=0.
  - PEND with wb_valid & wb_we & wb_addr==buf_addr: grant the buffer; wb_ready=0 (WAW order: the older LLU write goes first).
  - PEND with wb_valid & wb_we, different address: grant the pipeline; wb_ready=1; the buffer loses.
  - PEND with wb_valid & ~wb_we: pipeline retires (wb_ready=1) and the buffer drains in the same cycle.
  - PEND with ~wb_valid: grant the buffer.
  - IDLE: wb_ready=1.
REQ-013 Starvation counter (2 bits minimum, sized for STARVE_LIMIT): cleared on entry to PEND; increments on each PEND cycle in which the buffer loses; on reaching STARVE_LIMIT the next state is FORCE.
REQ-014 Transitions:
  - IDLE->PEND on accept.
  - PEND->IDLE on buffer grant.
  - PEND->FORCE per REQ-013.
  - FORCE->IDLE unconditionally after its single grant cycle.
REQ-015 A buffer grant clears full in the same edge; llu_ready rises the following cycle.
REQ-016 Latency: a grant in cycle N drives rf_we / rf_waddr / rf_wdata and the debug ports in cycle N+1, for exactly one cycle.
REQ-017 A write to address 0 is granted and retired normally, but drives rf_we=0 and debug_wb_rf_wen=4'b0000.
REQ-018 Debug wen SHALL be 4'b1111 when rf_we=1, else 4'b0000. When the pipeline retires with ~wb_we, debug_wb_pc reflects the buffer PC if the buffer drained that cycle, otherwise wb_pc with wen 0.
REQ-019 When no write is granted, rf_we=0 and the data/address outputs hold their previous values.

Reset
REQ-020 While reset is high: state=IDLE, full=0, counter=0, llu_ready=0, and rf_we, rf_waddr, rf_wdata and all debug outputs are 0. The cycle after reset deasserts, llu_ready=1.
REQ-021 Reset mid-operation discards any buffered result and suppresses any write granted in the same cycle.
REQ-022 wb_ready is 0 during reset.

Verification
REQ-023 Idle pipeline: wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x11 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11, debug_wb_rf_wen=4'b1111.
REQ-024 LLU write to r7=0xAB accepted with wb_valid=0 -> llu_ready=0 in the next cycle; buffer granted that cycle; rf_we=1 / r7 / 0xAB the cycle after; llu_ready=1 again.
REQ-025 Buffer full, pipeline writes r3 every cycle -> pipeline wins 3 cycles, then FORCE: wb_ready=0 for one cycle and the buffered write appears the next cycle.
REQ-026 Buffer holds r9; pipeline writes r9 -> wb_ready=0 that cycle; write order is buffer r9, then pipeline r9.
REQ-027 Buffer full; pipeline store (wb_we=0) -> wb_ready=1 and the buffer drains in the same cycle; debug_wb_pc = buffered PC.
REQ-028 Pipeline writes r0 -> rf_we=0 and debug wen 0; reset asserted with the buffer full -> full=0 and no write is issued afterwards.
